// File: rtl/scaled_frame_packer.sv
// Packs the scaler's vsync/href pixel stream into a valid/ready stream with SOF/EOL
// markers, buffering through a FIFO and flagging line-width framing errors.
`timescale 1ns/1ps
module scaled_frame_packer #(
  parameter int FIFO_AW = 9,
  parameter int MAX_W   = 12
) (
  input  logic             clk_in2,
  input  logic             rst,
  input  logic             per_img_vsync,
  input  logic             per_img_href,
  input  logic [31:0]      per_img_data,
  input  logic [MAX_W-1:0] c_dst_img_width,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tuser,
  output logic             m_tlast,
  output logic [MAX_W-1:0] line_cnt,
  output logic             err_ovf,
  output logic             err_short,
  output logic             err_long,
  input  logic             err_clr
);

  typedef logic [MAX_W-1:0] cnt_t;
  typedef logic [FIFO_AW:0] ptr_t;
  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } word_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    if (&v) return v;
    return v + cnt_t'(1);
  endfunction

  logic  vsync_q, href_q;
  cnt_t  width_q, width_d, pcnt_q, pcnt_d, lcnt_q, lcnt_d;
  logic  sof_q, sof_d;
  logic  hold_vld_q, hold_vld_d;
  word_t hold_q, hold_d;
  ptr_t  wptr_q, wptr_d, rptr_q, rptr_d;
  word_t mem [0:(1<<FIFO_AW)-1];
  logic  out_vld_q, out_vld_d;
  word_t out_q, out_d;
  logic  ovf_q, ovf_d, short_q, short_d, long_q, long_d;

  logic  vs_rise, hs_fall, line_end, sof_eff;
  logic  pix_keep, pix_drop, pix_last, short_end;
  cnt_t  width_eff, pbase;
  logic  commit, full, empty, pop, push;
  word_t commit_word, rd_word;
  logic  unused_hi;

  assign unused_hi = ^per_img_data[31:24];

  // A vsync edge while href was high closes the in-flight line before restarting the frame.
  always_comb begin
    vs_rise     = per_img_vsync & ~vsync_q;
    hs_fall     = ~per_img_href & href_q;
    line_end    = hs_fall | (vs_rise & href_q);
    width_eff   = vs_rise ? c_dst_img_width : width_q;
    pbase       = (vs_rise | hs_fall) ? '0 : pcnt_q;
    sof_eff     = vs_rise | sof_q;
    pix_keep    = per_img_href & ((width_eff == '0) | (pbase < width_eff));
    pix_drop    = per_img_href & ~pix_keep;
    pix_last    = pix_keep & (width_eff != '0) & (pbase == width_eff - cnt_t'(1));
    short_end   = line_end & (width_q != '0) & (pcnt_q != '0) & (pcnt_q < width_q);
    commit      = hold_vld_q & (per_img_href | line_end);
    commit_word = hold_q;
    commit_word.last = hold_q.last | line_end;
    empty       = (wptr_q == rptr_q);
    full        = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    pop         = ~empty & (~out_vld_q | m_tready);
    push        = commit & (~full | pop);
    rd_word     = mem[rptr_q[FIFO_AW-1:0]];
  end

  always_comb begin
    width_d    = vs_rise ? c_dst_img_width : width_q;
    pcnt_d     = per_img_href ? sat_inc(pbase) : pbase;
    sof_d      = pix_keep ? 1'b0 : sof_eff;
    hold_vld_d = hold_vld_q & ~commit;
    hold_d     = hold_q;
    if (pix_keep) begin
      hold_vld_d = 1'b1;
      hold_d     = '{data: {8'h00, per_img_data[23:0]}, user: sof_eff, last: pix_last};
    end

    // Short or unchecked lines count at their end; full-width lines count at their last pixel.
    lcnt_d = lcnt_q;
    if (hs_fall && ((width_q == '0) || short_end)) lcnt_d = sat_inc(lcnt_d);
    if (vs_rise) lcnt_d = '0;
    if (pix_last) lcnt_d = sat_inc(lcnt_d);

    wptr_d    = push ? wptr_q + ptr_t'(1) : wptr_q;
    rptr_d    = pop  ? rptr_q + ptr_t'(1) : rptr_q;
    out_vld_d = out_vld_q;
    out_d     = out_q;
    if (pop) begin
      out_vld_d = 1'b1;
      out_d     = rd_word;
    end else if (m_tready) begin
      out_vld_d = 1'b0;
    end

    ovf_d   = (err_clr ? 1'b0 : ovf_q)   | (commit & ~push);
    short_d = (err_clr ? 1'b0 : short_q) | short_end;
    long_d  = (err_clr ? 1'b0 : long_q)  | pix_drop;
  end

  always_ff @(posedge clk_in2) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      width_q    <= '0;
      pcnt_q     <= '0;
      lcnt_q     <= '0;
      sof_q      <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      vsync_q    <= per_img_vsync;
      href_q     <= per_img_href;
      width_q    <= width_d;
      pcnt_q     <= pcnt_d;
      lcnt_q     <= lcnt_d;
      sof_q      <= sof_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      short_q    <= short_d;
      long_q     <= long_d;
    end
  end

  always_ff @(posedge clk_in2) begin
    if (push) mem[wptr_q[FIFO_AW-1:0]] <= commit_word;
  end

  assign m_tdata   = out_q.data;
  assign m_tuser   = out_q.user;
  assign m_tlast   = out_q.last;
  assign m_tvalid  = out_vld_q;
  assign line_cnt  = lcnt_q;
  assign err_ovf   = ovf_q;
  assign err_short = short_q;
  assign err_long  = long_q;

endmodule
